// File: rtl/dbg_dump_tx.sv
// Debug dump transmit engine: streams a snapshot of one channel slice to uart_tx,
// optionally followed by an XOR checksum, always terminated by READY_CHAR.
module dbg_dump_tx #(
   parameter int         NUM_CH     = 8,
   parameter int         CH_BYTES   = 32,
   parameter int         CH_SEL_W   = $clog2(NUM_CH),
   parameter int         LEN_W      = $clog2(CH_BYTES + 1),
   parameter logic [7:0] READY_CHAR = 8'h52,
   parameter int         TIMEOUT    = 65535
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_req_valid,
   output logic                         o_req_ready,
   input  logic [CH_SEL_W-1:0]          i_req_ch,
   input  logic [LEN_W-1:0]             i_req_len,
   input  logic                         i_cksum_en,
   input  logic [NUM_CH*CH_BYTES*8-1:0] i_ch_data,
   output logic                         o_tx_start,
   output logic [7:0]                   o_tx_data,
   input  logic                         i_tx_done,
   output logic                         o_busy,
   output logic                         o_done,
   output logic                         o_err
);

   localparam int SNAP_W = CH_BYTES * 8;
   localparam int IDX_W  = (CH_BYTES > 1) ? $clog2(CH_BYTES) : 1;
   localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WCNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? WCNT_W'(TIMEOUT - 1) : '0;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SEND     = 3'd1;
   localparam logic [2:0] S_WAIT     = 3'd2;
   localparam logic [2:0] S_CKSUM    = 3'd3;
   localparam logic [2:0] S_CKWAIT   = 3'd4;
   localparam logic [2:0] S_TERM     = 3'd5;
   localparam logic [2:0] S_TERMWAIT = 3'd6;
   localparam logic [2:0] S_DONE     = 3'd7;

   logic [2:0]        state_q, state_d;
   logic [SNAP_W-1:0] snap_q, snap_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              cksum_en_q, cksum_en_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [7:0]        cksum_q, cksum_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              err_q, err_d;

   logic [SNAP_W-1:0] slices [NUM_CH];
   logic [7:0]        snap_bytes [CH_BYTES];
   logic [SNAP_W-1:0] sel_slice;
   logic [7:0]        cur_byte;
   logic              req_ok;
   logic              timeout_hit;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_slice
      assign slices[g] = i_ch_data[g*SNAP_W +: SNAP_W];
   end
   for (genvar g = 0; g < CH_BYTES; g++) begin : g_byte
      assign snap_bytes[g] = snap_q[g*8 +: 8];
   end

   assign sel_slice   = slices[i_req_ch];
   assign cur_byte    = snap_bytes[idx_q[IDX_W-1:0]];
   assign req_ok      = (i_req_len != '0) && (i_req_len <= LEN_W'(CH_BYTES)) &&
                        (32'(i_req_ch) < 32'(NUM_CH));
   assign timeout_hit = (TIMEOUT != 0) && (wcnt_q == TO_LAST);

   always_comb begin
      state_d    = state_q;
      snap_d     = snap_q;
      len_d      = len_q;
      cksum_en_d = cksum_en_q;
      idx_d      = idx_q;
      cksum_d    = cksum_q;
      wcnt_d     = wcnt_q;
      err_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_req_valid) begin
               if (req_ok) begin
                  snap_d     = sel_slice;
                  len_d      = i_req_len;
                  cksum_en_d = i_cksum_en;
                  idx_d      = '0;
                  cksum_d    = '0;
                  state_d    = S_SEND;
               end else begin
                  // Bad request still answers with the terminator so the host never stalls
                  err_d   = 1'b1;
                  state_d = S_TERM;
               end
            end
         end
         S_SEND: begin
            wcnt_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (i_tx_done) begin
               cksum_d = cksum_q ^ cur_byte;
               idx_d   = idx_q + LEN_W'(1);
               if ((idx_q + LEN_W'(1)) < len_q) state_d = S_SEND;
               else if (cksum_en_q)             state_d = S_CKSUM;
               else                             state_d = S_TERM;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wcnt_d = wcnt_q + WCNT_W'(1);
            end
         end
         S_CKSUM: begin
            wcnt_d  = '0;
            state_d = S_CKWAIT;
         end
         S_CKWAIT: begin
            if (i_tx_done) begin
               state_d = S_TERM;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wcnt_d = wcnt_q + WCNT_W'(1);
            end
         end
         S_TERM: begin
            wcnt_d  = '0;
            state_d = S_TERMWAIT;
         end
         S_TERMWAIT: begin
            if (i_tx_done) begin
               state_d = S_DONE;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wcnt_d = wcnt_q + WCNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         snap_q     <= '0;
         len_q      <= '0;
         cksum_en_q <= 1'b0;
         idx_q      <= '0;
         cksum_q    <= '0;
         wcnt_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         snap_q     <= snap_d;
         len_q      <= len_d;
         cksum_en_q <= cksum_en_d;
         idx_q      <= idx_d;
         cksum_q    <= cksum_d;
         wcnt_q     <= wcnt_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      o_tx_data = '0;
      case (state_q)
         S_SEND, S_WAIT:       o_tx_data = cur_byte;
         S_CKSUM, S_CKWAIT:    o_tx_data = cksum_q;
         S_TERM, S_TERMWAIT:   o_tx_data = READY_CHAR;
         default:              o_tx_data = '0;
      endcase
   end

   assign o_tx_start  = (state_q == S_SEND) || (state_q == S_CKSUM) || (state_q == S_TERM);
   assign o_req_ready = (state_q == S_IDLE);
   assign o_busy      = (state_q != S_IDLE);
   assign o_done      = (state_q == S_DONE);
   assign o_err       = err_q;

endmodule
